// File: rtl/game_sequencer.sv
// Game flow sequencer: IDLE -> COUNTDOWN -> RUNNING -> DYING/GAME_OVER/WIN, stepped on game_tick.
// Define GAME_SEQUENCER_LIVES_EN to build the lives counter and the DYING state.
//
// state        | meaning
// IDLE         | waiting for a start edge, player and lava frozen
// COUNTDOWN    | pre-round countdown, countdown output shows seconds left
// RUNNING      | play active, jumps score, death/goal end the round
// DYING        | life lost, hold then restart the countdown (lives build only)
// GAME_OVER    | no lives left, start accepted after the hold time
// WIN          | goal reached, start accepted after the hold time
module game_sequencer #(
    parameter int COUNTDOWN_SEC = 3,
    parameter int TICKS_PER_SEC = 60,
    parameter int HOLD_TICKS    = 120,
    parameter int LIVES_INIT    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_tick,
    input  logic        start_btn,
    input  logic        death_evt,
    input  logic        goal_evt,
    input  logic        jump_landed,
    output logic        freeze,
    output logic        soft_rst_n,
    output logic        lava_boost,
    output logic [2:0]  state,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [1:0]  countdown
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_DYING     = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    // One down-counter serves both the per-second countdown and the end-of-round hold.
    localparam int TMR_MAX = (HOLD_TICKS > TICKS_PER_SEC) ? HOLD_TICKS : TICKS_PER_SEC;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] SEC_LOAD  = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_TICKS - 1);
    localparam logic [1:0]    CD_LOAD   = 2'(COUNTDOWN_SEC);
    localparam logic [1:0]    LIVES_LOAD = 2'(LIVES_INIT);

    if (COUNTDOWN_SEC < 1 || COUNTDOWN_SEC > 3) begin : g_bad_countdown
        $error("game_sequencer: COUNTDOWN_SEC must be 1..3");
    end
    if (LIVES_INIT < 1 || LIVES_INIT > 3) begin : g_bad_lives
        $error("game_sequencer: LIVES_INIT must be 1..3");
    end
    if (TICKS_PER_SEC < 1 || HOLD_TICKS < 1) begin : g_bad_timing
        $error("game_sequencer: TICKS_PER_SEC and HOLD_TICKS must be >= 1");
    end

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [15:0]     score_q, score_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            boost_q, boost_d;
    logic            soft_q, soft_d;
    logic            freeze_q;
    logic            start_prev_q;
    logic            start_pend_q, start_pend_d;
    logic            jump_pend_q, jump_pend_d;
    logic            start_req, jump_req;
    logic            enter_cd, new_game;
`ifdef GAME_SEQUENCER_LIVES_EN
    logic [1:0]      lives_q, lives_d;
`endif

    // Pending requests include an event arriving on the tick cycle itself.
    always_comb begin
        start_req    = start_pend_q | (start_btn & ~start_prev_q);
        jump_req     = jump_pend_q | jump_landed;
        start_pend_d = game_tick ? 1'b0 : start_req;
        jump_pend_d  = game_tick ? 1'b0 : jump_req;
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        score_d  = score_q;
        cnt_d    = cnt_q;
        boost_d  = boost_q;
        soft_d   = 1'b1;
        enter_cd = 1'b0;
        new_game = 1'b0;
`ifdef GAME_SEQUENCER_LIVES_EN
        lives_d  = lives_q;
`endif
        if (game_tick) begin
            boost_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        new_game = 1'b1;
                        enter_cd = 1'b1;
                    end
                end
                ST_COUNTDOWN: begin
                    if (tmr_q == '0) begin
                        if (cnt_q == 2'd1) begin
                            state_d = ST_RUNNING;
                            cnt_d   = 2'd0;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                            tmr_d = SEC_LOAD;
                        end
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (death_evt) begin
                        tmr_d = HOLD_LOAD;
`ifdef GAME_SEQUENCER_LIVES_EN
                        lives_d = lives_q - 2'd1;
                        state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_DYING;
`else
                        state_d = ST_GAME_OVER;
`endif
                    end else if (goal_evt) begin
                        tmr_d   = HOLD_LOAD;
                        state_d = ST_WIN;
                    end else if (jump_req) begin
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
                        boost_d = 1'b1;
                    end
                end
`ifdef GAME_SEQUENCER_LIVES_EN
                ST_DYING: begin
                    if (tmr_q == '0) begin
                        enter_cd = 1'b1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
`endif
                ST_GAME_OVER, ST_WIN: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - 1'b1;
                    end else if (start_req) begin
                        new_game = 1'b1;
                        enter_cd = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                    cnt_d   = 2'd0;
                end
            endcase
        end
        if (enter_cd) begin
            state_d = ST_COUNTDOWN;
            cnt_d   = CD_LOAD;
            tmr_d   = SEC_LOAD;
            soft_d  = 1'b0;
        end
        if (new_game) begin
            score_d = 16'd0;
`ifdef GAME_SEQUENCER_LIVES_EN
            lives_d = LIVES_LOAD;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            score_q      <= 16'd0;
            cnt_q        <= 2'd0;
            boost_q      <= 1'b0;
            soft_q       <= 1'b1;
            freeze_q     <= 1'b1;
            start_prev_q <= 1'b0;
            start_pend_q <= 1'b0;
            jump_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            score_q      <= score_d;
            cnt_q        <= cnt_d;
            boost_q      <= boost_d;
            soft_q       <= soft_d;
            freeze_q     <= (state_d != ST_RUNNING);
            start_prev_q <= start_btn;
            start_pend_q <= start_pend_d;
            jump_pend_q  <= jump_pend_d;
        end
    end

`ifdef GAME_SEQUENCER_LIVES_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lives_q <= LIVES_LOAD;
        end else begin
            lives_q <= lives_d;
        end
    end
    assign lives = lives_q;
`else
    assign lives = 2'd0;
`endif

    assign state      = state_q;
    assign score      = score_q;
    assign countdown  = cnt_q;
    assign lava_boost = boost_q;
    assign soft_rst_n = soft_q;
    assign freeze     = freeze_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer at default parameters; game_tick every 4 clk.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_tick, start_btn, death_evt, goal_evt, jump_landed;
    logic        freeze, soft_rst_n, lava_boost;
    logic [2:0]  state;
    logic [15:0] score;
    logic [1:0]  lives, countdown;

    int checks   = 0;
    int failures = 0;
    int soft_lows;

`ifdef GAME_SEQUENCER_LIVES_EN
    localparam logic [1:0] LIVES_EXP = 2'd3;
`else
    localparam logic [1:0] LIVES_EXP = 2'd0;
`endif

    game_sequencer dut (
        .clk(clk), .rst(rst), .game_tick(game_tick), .start_btn(start_btn),
        .death_evt(death_evt), .goal_evt(goal_evt), .jump_landed(jump_landed),
        .freeze(freeze), .soft_rst_n(soft_rst_n), .lava_boost(lava_boost),
        .state(state), .score(score), .lives(lives), .countdown(countdown)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One game tick; counts how many sampled clk periods soft_rst_n was low.
    task automatic tick();
        soft_lows = 0;
        @(negedge clk) game_tick = 1'b1;
        @(negedge clk) game_tick = 1'b0;
        if (!soft_rst_n) soft_lows++;
        @(negedge clk);
        if (!soft_rst_n) soft_lows++;
        @(negedge clk);
        if (!soft_rst_n) soft_lows++;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press_start();
        @(negedge clk) start_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic pulse_jump();
        @(negedge clk) jump_landed = 1'b1;
        @(negedge clk) jump_landed = 1'b0;
    endtask

    initial begin
        rst = 1'b0; game_tick = 1'b0; start_btn = 1'b0;
        death_evt = 1'b0; goal_evt = 1'b0; jump_landed = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_state", state, 3'd0);
        chk("rst_freeze", freeze, 1'b1);
        chk("rst_soft", soft_rst_n, 1'b1);
        chk("rst_boost", lava_boost, 1'b0);
        chk("rst_score", score, 16'd0);
        chk("rst_lives", lives, LIVES_EXP);
        chk("rst_countdown", countdown, 2'd0);

        rst = 1'b1;
        run_ticks(2);
        chk("idle_no_start", state, 3'd0);

        press_start();
        tick();
        chk("start_soft_pulse", soft_lows, 1);
        chk("start_state", state, 3'd1);
        chk("start_cd", countdown, 2'd3);
        chk("start_freeze", freeze, 1'b1);

        for (int k = 1; k <= 180; k++) begin
            if (k == 100 || k == 180) pulse_jump();
            tick();
            if (k == 59)  chk("cd_t59", countdown, 2'd3);
            if (k == 60)  chk("cd_t60", countdown, 2'd2);
            if (k == 100) begin
                chk("cd_jump_boost", lava_boost, 1'b0);
                chk("cd_jump_score", score, 16'd0);
            end
            if (k == 119) chk("cd_t119", countdown, 2'd2);
            if (k == 120) chk("cd_t120", countdown, 2'd1);
            if (k == 179) begin
                chk("cd_t179_state", state, 3'd1);
                chk("cd_t179_cd", countdown, 2'd1);
            end
            if (k == 180) begin
                chk("run_state", state, 3'd2);
                chk("run_freeze", freeze, 1'b0);
                chk("run_cd", countdown, 2'd0);
                chk("run_no_soft", soft_lows, 0);
            end
        end
        tick();
        chk("stale_jump_dropped", score, 16'd0);

        for (int j = 1; j <= 5; j++) begin
            pulse_jump();
            tick();
            chk("jump_score", score, 16'(j));
            chk("jump_boost_on", lava_boost, 1'b1);
            tick();
            chk("jump_boost_off", lava_boost, 1'b0);
        end

        death_evt = 1'b1; goal_evt = 1'b1;
        pulse_jump();
        tick();
        death_evt = 1'b0; goal_evt = 1'b0;
        chk("combo_score", score, 16'd5);
        chk("combo_boost", lava_boost, 1'b0);
        chk("combo_freeze", freeze, 1'b1);
`ifdef GAME_SEQUENCER_LIVES_EN
        chk("death1_state", state, 3'd3);
        chk("death1_lives", lives, 2'd2);
        run_ticks(119);
        chk("dying_hold", state, 3'd3);
        tick();
        chk("dying_exit_state", state, 3'd1);
        chk("dying_exit_soft", soft_lows, 1);
        chk("dying_exit_lives", lives, 2'd2);
        chk("dying_exit_score", score, 16'd5);
        chk("dying_exit_cd", countdown, 2'd3);
        run_ticks(180);
        chk("rerun1", state, 3'd2);
        death_evt = 1'b1;
        tick();
        death_evt = 1'b0;
        chk("death2_state", state, 3'd3);
        chk("death2_lives", lives, 2'd1);
        chk("death2_score", score, 16'd5);
        run_ticks(300);
        chk("rerun2", state, 3'd2);
        death_evt = 1'b1;
        tick();
        death_evt = 1'b0;
        chk("death3_state", state, 3'd4);
        chk("death3_lives", lives, 2'd0);
        chk("death3_score", score, 16'd5);
`else
        chk("death_state", state, 3'd4);
        chk("death_lives", lives, 2'd0);
`endif

        run_ticks(49);
        press_start();
        tick();
        chk("go_early_start_state", state, 3'd4);
        chk("go_early_start_soft", soft_lows, 0);
        run_ticks(79);
        press_start();
        tick();
        chk("go_restart_state", state, 3'd1);
        chk("go_restart_score", score, 16'd0);
        chk("go_restart_lives", lives, LIVES_EXP);
        chk("go_restart_soft", soft_lows, 1);

        run_ticks(10);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("midrst_state", state, 3'd0);
        chk("midrst_freeze", freeze, 1'b1);
        chk("midrst_cd", countdown, 2'd0);
        @(negedge clk) rst = 1'b1;
        run_ticks(2);
        chk("postrst_idle", state, 3'd0);

        press_start();
        run_ticks(181);
        chk("run_again", state, 3'd2);
        pulse_jump(); tick();
        pulse_jump(); tick();
        chk("pre_win_score", score, 16'd2);
        goal_evt = 1'b1;
        tick();
        goal_evt = 1'b0;
        chk("win_state", state, 3'd5);
        chk("win_score", score, 16'd2);
        chk("win_boost", lava_boost, 1'b0);
        run_ticks(49);
        press_start();
        tick();
        chk("win_early_start", state, 3'd5);
        run_ticks(79);
        press_start();
        tick();
        chk("win_restart_state", state, 3'd1);
        chk("win_restart_score", score, 16'd0);
        chk("win_restart_lives", lives, LIVES_EXP);

        run_ticks(180);
        chk("run_sat", state, 3'd2);
        @(negedge clk) force dut.score_q = 16'hFFFF;
        @(negedge clk) release dut.score_q;
        pulse_jump();
        tick();
        chk("sat_score", score, 16'hFFFF);
        chk("sat_boost", lava_boost, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter COUNTDOWN_SEC, default 3, countdown length in seconds (1..3).
REQ-002 SHALL have parameter TICKS_PER_SEC, default 60, game ticks per second.
REQ-003 SHALL have parameter HOLD_TICKS, default 120, minimum dwell in DYING, GAME_OVER and WIN.
REQ-004 SHALL have parameter LIVES_INIT, default 3, lives at new game (1..3).
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port game_tick, input, 1, one-clk pulse at the frame rate.
REQ-008 SHALL have port start_btn, input, 1, start request level, active-high.
REQ-009 SHALL have port death_evt, input, 1, level: player in lava or hit by lava wall.
REQ-010 SHALL have port goal_evt, input, 1, level: player in goal region.
REQ-011 SHALL have port jump_landed, input, 1, one-clk pulse per completed jump.
REQ-012 SHALL have port freeze, output, 1, halts player and lava.
REQ-013 SHALL have port soft_rst_n, output, 1, active-low restart pulse to player and lava.
REQ-014 SHALL have port lava_boost, output, 1, lava speed-up request.
REQ-015 SHALL have port state, output, 3, current state code.
REQ-016 SHALL have port score, output, 16, jump score.
REQ-017 SHALL have port lives, output, 2, remaining lives.
REQ-018 SHALL have port countdown, output, 2, seconds remaining; 0 outside COUNTDOWN.

Function
REQ-019 SHALL encode states as IDLE=0, COUNTDOWN=1, RUNNING=2, DYING=3, GAME_OVER=4, WIN=5; codes 6 and 7 SHALL return to IDLE on the next tick.
REQ-020 SHALL latch a rising edge of start_btn and any jump_landed pulse into pending flags on any clk; a flag SHALL clear on the next game_tick whether or not it is used.
REQ-021 SHALL evaluate state transitions and counters only on game_tick cycles; outputs SHALL be registered and change on the clk after that tick.
REQ-022 SHALL drive freeze=0 only in RUNNING.
REQ-023 IDLE: a pending start SHALL load score=0 and lives=LIVES_INIT, pulse soft_rst_n low for exactly one clk, and go to COUNTDOWN.
REQ-024 COUNTDOWN: countdown SHALL show COUNTDOWN_SEC, then decrement every TICKS_PER_SEC ticks; after COUNTDOWN_SEC*TICKS_PER_SEC ticks the block SHALL enter RUNNING.
REQ-025 RUNNING: priority SHALL be death_evt > goal_evt > jump credit; a death or goal tick SHALL NOT add score.
REQ-026 Jump credit SHALL increment score, saturating at 16'hFFFF, and raise lava_boost for exactly one tick period (clear on the following tick).
REQ-027 On death_evt, lives SHALL decrement; if the result is 0, next state SHALL be GAME_OVER, otherwise DYING.
REQ-028 On goal_evt, next state SHALL be WIN.
REQ-029 DYING: after HOLD_TICKS ticks the block SHALL pulse soft_rst_n for one clk and enter COUNTDOWN, keeping score and lives.
REQ-030 GAME_OVER/WIN: start requests SHALL be discarded until HOLD_TICKS ticks have elapsed; a later start SHALL act as in REQ-023.
REQ-031 lava_boost SHALL be 0 in every state except RUNNING.

Reset
REQ-032 While rst=0, outputs SHALL be: state=IDLE, freeze=1, soft_rst_n=1, lava_boost=0, score=0, lives=LIVES_INIT, countdown=0, all counters and pending flags 0.
REQ-033 Reset asserted mid-game SHALL abort immediately; after release the block SHALL wait in IDLE for a new start edge.

Configuration
REQ-034 With GAME_SEQUENCER_LIVES_EN defined, the lives counter, the DYING state and REQ-027/REQ-029 SHALL be implemented.
REQ-035 Without GAME_SEQUENCER_LIVES_EN, lives SHALL be constant 0, DYING SHALL be unreachable, and any death SHALL go directly to GAME_OVER.

Verification
REQ-036 Reset release, start pulse 3 clk wide -> soft_rst_n low 1 clk; COUNTDOWN shows 3,2,1 for 60 ticks each; RUNNING entered on tick 180; freeze falls.
REQ-037 RUNNING, 5 jump_landed pulses on separate ticks -> score=5; lava_boost high for one tick period each time.
REQ-038 LIVES_EN, 3 lives, death_evt in RUNNING, repeated three times -> DYING, DYING, then GAME_OVER; lives 2,1,0; score retained.
REQ-039 death_evt, goal_evt and jump_landed on the same tick -> DYING (or GAME_OVER without LIVES_EN); score unchanged.
REQ-040 WIN, start at tick 50 then at tick 130 -> first start ignored; second gives score=0, lives=3, COUNTDOWN.
REQ-041 score=16'hFFFF plus a jump -> score stays 16'hFFFF; rst low during COUNTDOWN -> IDLE, freeze=1.
